// File: rtl/stepper_pkg.sv
// Purpose : shared types and helpers for the stepper phase monitor.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_ILLEGAL = 2'd1;
    localparam logic [1:0] FLT_SKIP    = 2'd2;

    localparam logic [3:0] PH_IN1 = 4'b0001;
    localparam logic [3:0] PH_IN2 = 4'b0010;
    localparam logic [3:0] PH_IN3 = 4'b0100;
    localparam logic [3:0] PH_IN4 = 4'b1000;

    // Clockwise successor: 0001 -> 1000 -> 0100 -> 0010 -> 0001
    function automatic logic [3:0] rot_right(input logic [3:0] p);
        return {p[0], p[3:1]};
    endfunction

    // Anti-clockwise successor: 0001 -> 0010 -> 0100 -> 1000 -> 0001
    function automatic logic [3:0] rot_left(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

    function automatic logic is_legal(input logic [3:0] p);
        return (p == PH_IN1) || (p == PH_IN2) || (p == PH_IN3) || (p == PH_IN4);
    endfunction

endpackage

// File: rtl/phase_glitch_filter.sv
// Purpose : optional 2-flop sync + stability counter on the 4 phase lines.
// Latency : FILT_CYC cycles to o_stable (plus 2 when PHASE_SYNC_EN is defined).
// Backpr. : none; free-running, o_changed is a one-cycle strobe.
// Ports   : i_clk, i_rst (sync, active-high), i_phase -> o_stable, o_changed.
// Macro   : PHASE_SYNC_EN adds the synchronizer in front of the filter.
module phase_glitch_filter #(
    parameter int FILT_CYC = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_phase,
    output logic [3:0] o_stable,
    output logic       o_changed
);

    localparam int CW = $clog2(FILT_CYC + 1);

    logic [3:0]    w_sample;
    logic [3:0]    r_last;
    logic [3:0]    r_stable;
    logic          r_changed;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

`ifdef PHASE_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_phase;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = i_phase;
`endif

    // Run length of the current sample; a new value restarts the run at 1.
    always_comb begin
        if (w_sample != r_last) begin
            w_cnt_nxt = CW'(1);
        end else if (r_cnt < CW'(FILT_CYC)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last    <= '0;
            r_cnt     <= '0;
            r_stable  <= '0;
            r_changed <= 1'b0;
        end else begin
            r_last    <= w_sample;
            r_cnt     <= w_cnt_nxt;
            r_changed <= 1'b0;
            if ((w_cnt_nxt == CW'(FILT_CYC)) && (w_sample != r_stable)) begin
                r_stable  <= w_sample;
                r_changed <= 1'b1;
            end
        end
    end

    assign o_stable  = r_stable;
    assign o_changed = r_changed;

endmodule

// File: rtl/stepper_phase_monitor.sv
// Purpose : decode filtered 4-phase one-hot drive into position/dir/period, flag faults/stalls.
// Latency : phase change -> o_step_pulse = FILT_CYC+1 cycles (2+FILT_CYC+1 with PHASE_SYNC_EN).
// Backpr. : none; outputs are level/pulse status, no handshake.
// Ports   : i_clk, i_rst, i_phase_in, i_clear -> o_position, o_dir, o_step_pulse,
//           o_step_period, o_period_valid, o_stalled, o_fault, o_fault_code.
// Macro   : PHASE_SYNC_EN (consumed by phase_glitch_filter).
module stepper_phase_monitor
    import stepper_pkg::*;
#(
    parameter int FILT_CYC  = 4,
    parameter int POS_W     = 16,
    parameter int PER_W     = 20,
    parameter int STALL_CYC = 200000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [3:0]              i_phase_in,
    input  logic                    i_clear,
    output logic signed [POS_W-1:0] o_position,
    output logic                    o_dir,
    output logic                    o_step_pulse,
    output logic [PER_W-1:0]        o_step_period,
    output logic                    o_period_valid,
    output logic                    o_stalled,
    output logic                    o_fault,
    output logic [1:0]              o_fault_code
);

    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};
    localparam logic [PER_W-1:0] STALL_V = PER_W'(STALL_CYC);

    logic [3:0] w_stable;
    logic       w_changed;

    phase_glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_phase   (i_phase_in),
        .o_stable  (w_stable),
        .o_changed (w_changed)
    );

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_ref;
    logic signed [POS_W-1:0] r_position;
    logic                    r_dir;
    logic                    r_step_pulse;
    logic [PER_W-1:0]        r_step_period;
    logic [PER_W-1:0]        r_per_cnt;
    logic                    r_period_valid;
    logic                    r_step_seen;
    logic                    r_stalled;
    logic                    r_fault;
    logic [1:0]              r_fault_code;

    logic       w_legal;
    logic       w_is_cw;
    logic       w_is_ccw;
    logic       w_seed;
    logic       w_step_ev;
    logic       w_fault_ev;
    logic [1:0] w_fault_kind;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_legal)    w_state_nxt = TRACK;
                TRACK:   if (w_fault_ev) w_state_nxt = FAULT;
                FAULT:   w_state_nxt = FAULT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: per-cycle events; clear suppresses all of them.
    always_comb begin
        w_legal      = is_legal(w_stable);
        w_is_cw      = (w_stable == rot_right(r_ref));
        w_is_ccw     = (w_stable == rot_left(r_ref));
        w_seed       = 1'b0;
        w_step_ev    = 1'b0;
        w_fault_ev   = 1'b0;
        w_fault_kind = FLT_NONE;
        if (!i_clear) begin
            case (r_state)
                IDLE: w_seed = w_legal;
                TRACK: begin
                    if (w_changed) begin
                        if (!w_legal) begin
                            w_fault_ev   = 1'b1;
                            w_fault_kind = FLT_ILLEGAL;
                        end else if (w_is_cw || w_is_ccw) begin
                            w_step_ev = 1'b1;
                        end else if (w_stable != r_ref) begin
                            // legal but two positions away: a phase was skipped
                            w_fault_ev   = 1'b1;
                            w_fault_kind = FLT_SKIP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ref          <= '0;
            r_position     <= '0;
            r_dir          <= 1'b0;
            r_step_pulse   <= 1'b0;
            r_step_period  <= '0;
            r_per_cnt      <= '0;
            r_period_valid <= 1'b0;
            r_step_seen    <= 1'b0;
            r_stalled      <= 1'b0;
            r_fault        <= 1'b0;
            r_fault_code   <= FLT_NONE;
        end else begin
            r_step_pulse <= w_step_ev;
            if (i_clear) begin
                r_position     <= '0;
                r_per_cnt      <= '0;
                r_period_valid <= 1'b0;
                r_step_seen    <= 1'b0;
                r_stalled      <= 1'b0;
                r_fault        <= 1'b0;
                r_fault_code   <= FLT_NONE;
            end else begin
                if (w_seed) begin
                    r_ref     <= w_stable;
                    r_per_cnt <= PER_W'(1);
                end
                if (w_step_ev) begin
                    r_ref         <= w_stable;
                    r_position    <= w_is_cw ? r_position + POS_W'(1) : r_position - POS_W'(1);
                    r_dir         <= w_is_ccw;
                    r_step_period <= r_per_cnt;
                    r_per_cnt     <= PER_W'(1);
                    r_step_seen   <= 1'b1;
                    r_stalled     <= 1'b0;
                    // the first step's count runs from TRACK entry, not from a step
                    if (r_step_seen) r_period_valid <= 1'b1;
                end else if ((r_state == TRACK) && !w_fault_ev) begin
                    if (r_per_cnt != PER_MAX) r_per_cnt <= r_per_cnt + PER_W'(1);
                    if (r_step_seen && (r_per_cnt >= STALL_V)) r_stalled <= 1'b1;
                end
                if (w_fault_ev) begin
                    r_fault      <= 1'b1;
                    r_fault_code <= w_fault_kind;
                    r_stalled    <= 1'b0;
                end
            end
        end
    end

    assign o_position     = r_position;
    assign o_dir          = r_dir;
    assign o_step_pulse   = r_step_pulse;
    assign o_step_period  = r_step_period;
    assign o_period_valid = r_period_valid;
    assign o_stalled      = r_stalled;
    assign o_fault        = r_fault;
    assign o_fault_code   = r_fault_code;

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// Purpose : directed stimulus with a pulse scoreboard for stepper_phase_monitor.
// Latency : expected step pulses are queued with their due cycle.
// Backpr. : n/a.
module tb_stepper_phase_monitor;
    import stepper_pkg::*;

    localparam int FILT  = 4;
    localparam int POS_W = 16;
    localparam int PER_W = 7;
    localparam int STALL = 100;
`ifdef PHASE_SYNC_EN
    localparam int LAT = 2 + FILT + 1;
`else
    localparam int LAT = FILT + 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clear;
    logic [3:0]              phase;
    logic signed [POS_W-1:0] position;
    logic                    dir;
    logic                    step_pulse;
    logic [PER_W-1:0]        step_period;
    logic                    period_valid;
    logic                    stalled;
    logic                    fault;
    logic [1:0]              fault_code;

    stepper_phase_monitor #(
        .FILT_CYC (FILT),
        .POS_W    (POS_W),
        .PER_W    (PER_W),
        .STALL_CYC(STALL)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_phase_in     (phase),
        .i_clear        (clear),
        .o_position     (position),
        .o_dir          (dir),
        .o_step_pulse   (step_pulse),
        .o_step_period  (step_period),
        .o_period_valid (period_valid),
        .o_stalled      (stalled),
        .o_fault        (fault),
        .o_fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                      at;
        logic signed [POS_W-1:0] pos;
        logic                    dir;
        logic                    chk_per;
        logic [PER_W-1:0]        per;
        logic                    pvalid;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic signed [POS_W-1:0] exp_pos;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every step pulse must match the oldest queued expectation.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && step_pulse) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: step_pulse 1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_position", position, e.pos);
                chk("pulse_dir", dir, e.dir);
                if (e.chk_per) chk("pulse_step_period", step_period, e.per);
                chk("pulse_period_valid", period_valid, e.pvalid);
            end
        end
    end

    // Drive a new pattern and hold it for 'hold' cycles; optionally queue a pulse.
    task automatic step_to(input logic [3:0] p, input int hold, input bit exp_pulse,
                           input bit ccw, input bit chk_per, input int per, input bit pv);
        exp_t x;
        @(posedge clk);
        #1;
        phase = p;
        if (exp_pulse) begin
            exp_pos   = ccw ? exp_pos - 1 : exp_pos + 1;
            x.at      = cyc + LAT;
            x.pos     = exp_pos;
            x.dir     = ccw;
            x.chk_per = chk_per;
            x.per     = PER_W'(per);
            x.pvalid  = pv;
            sb.push_back(x);
        end
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_position"}, position, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_step_pulse"}, step_pulse, 0);
        chk({tag, "_step_period"}, step_period, 0);
        chk({tag, "_period_valid"}, period_valid, 0);
        chk({tag, "_stalled"}, stalled, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_fault_code"}, fault_code, 0);
        chk({tag, "_state"}, dut.r_state, IDLE);
    endtask

    initial begin
        rst     = 1'b1;
        clear   = 1'b0;
        phase   = 4'b0000;
        exp_pos = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 0000 held after reset: stays IDLE
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_on_0000_state", dut.r_state, IDLE);

        // Seed TRACK with 0001: no pulse
        step_to(4'b0001, 30, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("seed_state", dut.r_state, TRACK);
        chk("seed_position", position, 0);
        chk("seed_fault", fault, 0);

        // Four anti-clockwise steps, 50 cycles apart
        step_to(4'b0010, 50, 1, 1, 0, 0, 0);
        step_to(4'b0100, 50, 1, 1, 1, 50, 1);
        step_to(4'b1000, 50, 1, 1, 1, 50, 1);
        step_to(4'b0001, 50, 1, 1, 1, 50, 1);
        @(negedge clk);
        chk("ccw_position", position, -4);
        chk("ccw_dir", dir, 1);

        // Two clockwise steps, then a sub-threshold glitch
        step_to(4'b1000, 50, 1, 0, 1, 50, 1);
        step_to(4'b0100, 50, 1, 0, 1, 50, 1);
        step_to(4'b1111, FILT - 1, 0, 0, 0, 0, 0);
        step_to(4'b0100, 30, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("cw_position", position, -2);
        chk("cw_dir", dir, 0);
        chk("glitch_fault", fault, 0);
        chk("glitch_state", dut.r_state, TRACK);

        // Opposite phase: SKIP fault, then frozen
        step_to(4'b0001, 20, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("skip_fault", fault, 1);
        chk("skip_fault_code", fault_code, FLT_SKIP);
        chk("skip_state", dut.r_state, FAULT);
        step_to(4'b0010, 20, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("fault_frozen_position", position, -2);
        chk("fault_sticky", fault, 1);

        // Clear: IDLE next cycle, re-seeded TRACK the cycle after
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_pos = '0;
        @(negedge clk);
        chk("clear_state", dut.r_state, IDLE);
        chk("clear_position", position, 0);
        chk("clear_fault", fault, 0);
        chk("clear_fault_code", fault_code, 0);
        chk("clear_period_valid", period_valid, 0);
        @(negedge clk);
        chk("reseed_state", dut.r_state, TRACK);
        chk("reseed_ref", dut.r_ref, 4'b0010);

        // Stall: one step, then hold well past STALL cycles; period saturates
        step_to(4'b0001, 1, 1, 0, 0, 0, 0);
        repeat (LAT + 90) @(posedge clk);
        @(negedge clk);
        chk("stall_before", stalled, 0);
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("stall_after", stalled, 1);
        repeat (150 - 1 - (LAT + 115)) @(posedge clk);
        step_to(4'b1000, 20, 1, 0, 1, 127, 1);
        @(negedge clk);
        chk("stall_cleared", stalled, 0);
        chk("stall_period_sat", step_period, 127);

        // Illegal pattern in TRACK
        step_to(4'b0011, 20, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("illegal_fault", fault, 1);
        chk("illegal_fault_code", fault_code, FLT_ILLEGAL);
        chk("illegal_position", position, 2);

        // Reset while in FAULT
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("fault_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("post_reset_illegal_state", dut.r_state, IDLE);
        chk("post_reset_illegal_fault", fault, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
